// File: rtl/pdm_pkg.sv
// Shared types and constants for the stereo PDM microphone path.
// Imported by the timebase and the controller.
package pdm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN,
        S_STOP
    } state_t;

    // Strobe positions, counted back from each clock edge
    localparam int L_OFS = 3;
    localparam int R_OFS = 2;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pdm_mic_ctrl_timebase.sv
// PDM bit clock, phase/period counters and raw sample/frame strobes.
// Everything is held at zero while run is low.
module pdm_timebase
    import pdm_pkg::*;
#(
    parameter int HALF_DIV = 10,
    parameter int DECIM    = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic pdm_din,
    output logic clk_pdm,
    output logic din_l,
    output logic din_r,
    output logic stb_l,
    output logic stb_r,
    output logic stb_pcm
);

    localparam int PERIOD = 2 * HALF_DIV;
    localparam int PW     = cw(PERIOD);
    localparam int DW     = cw(DECIM);

    localparam logic [PW-1:0] PH_L   = PW'(HALF_DIV - L_OFS);
    localparam logic [PW-1:0] PH_R   = PW'(PERIOD - R_OFS);
    localparam logic [PW-1:0] PH_HI  = PW'(HALF_DIV);
    localparam logic [PW-1:0] PH_END = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DV_END = DW'(DECIM - 1);

    logic [PW-1:0] ph;
    logic [DW-1:0] div;
    logic          wrap;
    logic          frame_end;

    assign wrap      = (ph == PH_END);
    assign frame_end = wrap && (div == DV_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph      <= '0;
            div     <= '0;
            clk_pdm <= 1'b0;
            din_l   <= 1'b0;
            din_r   <= 1'b0;
            stb_l   <= 1'b0;
            stb_r   <= 1'b0;
            stb_pcm <= 1'b0;
        end else if (!run) begin
            ph      <= '0;
            div     <= '0;
            clk_pdm <= 1'b0;
            stb_l   <= 1'b0;
            stb_r   <= 1'b0;
            stb_pcm <= 1'b0;
        end else begin
            ph <= wrap ? '0 : ph + PW'(1);
            if (wrap) begin
                div <= (div == DV_END) ? '0 : div + DW'(1);
            end
            if (ph == '0) begin
                clk_pdm <= 1'b0;
            end else if (ph == PH_HI) begin
                clk_pdm <= 1'b1;
            end
            // Data latched one cycle ahead of the integrator strobe
            stb_l <= (ph == PH_L);
            if (ph == PH_L) begin
                din_l <= pdm_din;
            end
            stb_r <= (ph == PH_R);
            if (ph == PH_R) begin
                din_r <= pdm_din;
            end
            stb_pcm <= frame_end;
        end
    end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// Stereo PDM capture sequencer: run/settle/stop control, frame capture
// from the CIC lanes and a valid/ready output stage with overrun flag.
module pdm_mic_ctrl
    import pdm_pkg::*;
#(
    parameter int W        = 16,
    parameter int HALF_DIV = 10,
    parameter int DECIM    = 64,
    parameter int SETTLE   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic         clk_pdm,
    input  logic         pdm_din,
    output logic         din_l,
    output logic         din_r,
    output logic         en_sample_l,
    output logic         en_sample_r,
    output logic         en_pcm,
    input  logic [W-1:0] cic_l,
    input  logic [W-1:0] cic_r,
    output logic [W-1:0] pcm_l,
    output logic [W-1:0] pcm_r,
    output logic         pcm_valid,
    input  logic         pcm_ready,
    output logic         overrun,
    input  logic         clr_overrun
);

    localparam int SW = cw(SETTLE + 1);
    localparam logic [SW-1:0] SET_END = SW'(SETTLE);

    state_t        state;
    state_t        state_d;
    logic          from_run;
    logic [SW-1:0] set_cnt;
    logic          cap_now;
    logic          cap_pend;
    logic          run;

    // Gate on both sides so ph starts at 0 on entry and is 0 on exit
    assign run = (state != S_IDLE) && (state_d != S_IDLE);

    pdm_timebase #(
        .HALF_DIV (HALF_DIV),
        .DECIM    (DECIM)
    ) u_tb (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .pdm_din (pdm_din),
        .clk_pdm (clk_pdm),
        .din_l   (din_l),
        .din_r   (din_r),
        .stb_l   (en_sample_l),
        .stb_r   (en_sample_r),
        .stb_pcm (en_pcm)
    );

    always_comb begin
        state_d = state;
        cap_now = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (en_pcm && set_cnt == SET_END) begin
                    cap_now = 1'b1;
                    state_d = S_RUN;
                end
                if (!enable) begin
                    state_d = S_STOP;
                end
            end
            S_RUN: begin
                cap_now = en_pcm;
                if (!enable) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (en_pcm) begin
                    cap_now = from_run;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            from_run <= 1'b0;
            set_cnt  <= '0;
        end else begin
            state <= state_d;
            if (state != S_STOP && state_d == S_STOP) begin
                from_run <= (state == S_RUN) || cap_now;
            end
            if (state == S_IDLE) begin
                set_cnt <= '0;
            end else if (state == S_SETTLE && en_pcm &&
                         set_cnt != SET_END) begin
                set_cnt <= set_cnt + SW'(1);
            end
        end
    end

    // CIC output is sampled one cycle after en_pcm (comb latency)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_pend  <= 1'b0;
            pcm_l     <= '0;
            pcm_r     <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cap_pend <= cap_now;
            if (cap_pend && (!pcm_valid || pcm_ready)) begin
                pcm_l     <= cic_l;
                pcm_r     <= cic_r;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
            if (cap_pend && pcm_valid && !pcm_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed bench for pdm_mic_ctrl at default parameters.
// Cycle 0 is the first SETTLE cycle after enable is taken.
module tb_pdm_mic_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         clk_pdm;
    logic         pdm_din;
    logic         din_l;
    logic         din_r;
    logic         en_sample_l;
    logic         en_sample_r;
    logic         en_pcm;
    logic [W-1:0] cic_l;
    logic [W-1:0] cic_r;
    logic [W-1:0] pcm_l;
    logic [W-1:0] pcm_r;
    logic         pcm_valid;
    logic         pcm_ready;
    logic         overrun;
    logic         clr_overrun;

    always #5 clk = ~clk;

    pdm_mic_ctrl #(
        .W        (W),
        .HALF_DIV (10),
        .DECIM    (64),
        .SETTLE   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clk_pdm     (clk_pdm),
        .pdm_din     (pdm_din),
        .din_l       (din_l),
        .din_r       (din_r),
        .en_sample_l (en_sample_l),
        .en_sample_r (en_sample_r),
        .en_pcm      (en_pcm),
        .cic_l       (cic_l),
        .cic_r       (cic_r),
        .pcm_l       (pcm_l),
        .pcm_r       (pcm_r),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    logic [2*W+7:0] outs;
    assign outs = {clk_pdm, din_l, din_r, en_sample_l, en_sample_r,
                   en_pcm, pcm_valid, overrun, pcm_l, pcm_r};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int f_l, f_r, f_pcm, f_rise, f_fall, f_val;
    int n_l, n_pcm, n_val;
    logic [W-1:0] v_l, v_r;
    logic prev_clk, prev_val, act, any_out;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic arm();
        f_l = -1; f_r = -1; f_pcm = -1;
        f_rise = -1; f_fall = -1; f_val = -1;
        n_l = 0; n_pcm = 0; n_val = 0;
        v_l = '0; v_r = '0;
        prev_clk = clk_pdm;
        prev_val = pcm_valid;
        act = 1'b0;
        any_out = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (en_sample_l) begin
            n_l++;
            if (f_l < 0) f_l = cyc;
        end
        if (en_sample_r && f_r < 0) f_r = cyc;
        if (en_pcm) begin
            n_pcm++;
            if (f_pcm < 0) f_pcm = cyc;
        end
        if (!prev_clk && clk_pdm && f_rise < 0) f_rise = cyc;
        if (prev_clk && !clk_pdm && f_rise >= 0 && f_fall < 0)
            f_fall = cyc;
        if (pcm_valid) n_val++;
        if (pcm_valid && !prev_val && f_val < 0) begin
            f_val = cyc;
            v_l = pcm_l;
            v_r = pcm_r;
        end
        act = act | clk_pdm | en_sample_l | en_sample_r | en_pcm;
        any_out = any_out | (|outs);
        prev_clk = clk_pdm;
        prev_val = pcm_valid;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic start();
        enable = 1'b1;
        step();
        cyc = 0;
        arm();
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        pdm_din = 1'b0;
        cic_l = '0;
        cic_r = '0;
        pcm_ready = 1'b0;
        clr_overrun = 1'b0;
        arm();
        repeat (3) step();
        check("reset_outs", outs, '0);

        rst_n = 1'b1;
        arm();
        repeat (100) step();
        check("idle_quiet", any_out, 1'b0);

        // Timing and first delivered frame
        pdm_din = 1'b1;
        cic_l = 16'h1234;
        cic_r = 16'hFEDC;
        pcm_ready = 1'b1;
        start();
        run_to(8);
        check("din_l_latch1", din_l, 1'b1);
        run_to(19);
        check("din_r_latch1", din_r, 1'b1);
        pdm_din = 1'b0;
        run_to(26);
        check("din_l_hold", din_l, 1'b1);
        run_to(28);
        check("din_l_latch0", din_l, 1'b0);
        run_to(1279);
        check("n_sample_l", n_l, 64);
        check("no_early_pcm", n_pcm, 0);
        run_to(1300);
        check("first_l", f_l, 8);
        check("first_r", f_r, 19);
        check("first_pcm", f_pcm, 1280);
        check("clk_rise", f_rise, 11);
        check("clk_fall", f_fall, 21);
        run_to(6403);
        check("n_pcm_settle", n_pcm, 5);
        check("first_valid", f_val, 6402);
        check("first_pcm_l", v_l, 16'h1234);
        check("first_pcm_r", v_r, 16'hFEDC);
        check("valid_drop", pcm_valid, 1'b0);

        // Overrun: held frame, sticky flag, clear, set-wins
        pcm_ready = 1'b0;
        cic_l = 16'h1111;
        cic_r = 16'h2222;
        run_to(8961);
        check("ovr_before", overrun, 1'b0);
        cic_l = 16'h3333;
        cic_r = 16'h4444;
        run_to(8962);
        check("ovr_set", overrun, 1'b1);
        check("hold_l", pcm_l, 16'h1111);
        check("hold_r", pcm_r, 16'h2222);
        check("hold_valid", pcm_valid, 1'b1);
        run_to(8965);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_clr", overrun, 1'b0);
        run_to(10241);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        check("hold_l2", pcm_l, 16'h1111);
        run_to(10245);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;

        // Accept coinciding with capture
        cic_l = 16'h4444;
        cic_r = 16'h5555;
        run_to(11521);
        pcm_ready = 1'b1;
        step();
        check("acc_cap_valid", pcm_valid, 1'b1);
        check("acc_cap_l", pcm_l, 16'h4444);
        check("acc_cap_r", pcm_r, 16'h5555);
        check("acc_cap_ovr", overrun, 1'b0);
        step();
        check("acc_drop", pcm_valid, 1'b0);

        // Stop mid-frame in RUN
        cic_l = 16'h6666;
        cic_r = 16'h7777;
        run_to(12000);
        enable = 1'b0;
        arm();
        run_to(12800);
        check("stop_n_l", n_l, 40);
        check("stop_pcm", f_pcm, 12800);
        act = 1'b0;
        run_to(13000);
        check("stop_quiet", act, 1'b0);
        check("stop_valid", f_val, 12802);
        check("stop_pcm_l", v_l, 16'h6666);
        check("stop_pcm_r", v_r, 16'h7777);
        check("stop_clk", clk_pdm, 1'b0);

        // Reset pulse mid-frame
        cic_l = 16'hAAAA;
        cic_r = 16'h5555;
        start();
        run_to(700);
        rst_n = 1'b0;
        step();
        check("rst_mid_outs", outs, '0);
        rst_n = 1'b1;
        enable = 1'b0;
        arm();
        repeat (1400) step();
        check("rst_no_frame", n_val, 0);
        check("rst_quiet", any_out, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_mic_ctrl.md
Name: pdm_mic_ctrl

Overview:
Sequencer and output stage for the stereo PDM microphone path. It generates the PDM bit clock and captures left and right PDM bits on opposite clock phases. It drives sample and decimation strobes into two per-channel CIC lanes and discards CIC output while the filter settles after start. It then delivers stereo PCM frames to the consumer over a valid/ready handshake with overrun detection.

Parameters:
W, 16, PCM sample width (matches CIC lane width)
HALF_DIV, 10, clk cycles per PDM clock half-period (PDM period = 2*HALF_DIV, min 4)
DECIM, 64, PDM periods per PCM frame
SETTLE, 4, PCM frames discarded after start (0 = none)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  level; 1 = run capture, 0 = stop at next frame boundary
clk_pdm  out  1  PDM bit clock to microphones
pdm_din  in  1  shared PDM data line
din_l  out  1  latched left PDM bit to left CIC
din_r  out  1  latched right PDM bit to right CIC
en_sample_l  out  1  one-cycle strobe, left CIC integrator enable
en_sample_r  out  1  one-cycle strobe, right CIC integrator enable
en_pcm  out  1  one-cycle strobe, comb enable for both CICs
cic_l  in  W  left CIC output
cic_r  in  W  right CIC output
pcm_l  out  W  captured left sample
pcm_r  out  W  captured right sample
pcm_valid  out  1  frame available
pcm_ready  in  1  consumer accepts when valid&&ready
overrun  out  1  sticky; a frame was dropped
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0, counters 0. Reset mid-frame aborts immediately with no partial output.
- Counters:
  - phase counter ph: 0..2*HALF_DIV-1.
  - period counter div: 0..DECIM-1.
  - settle counter: 0..SETTLE.
- FSM states:
  - IDLE: ph and div held at 0, clk_pdm=0, no strobes. enable=1 -> SETTLE, and ph starts at 0 the next cycle.
  - SETTLE: clocking and strobes run. On each en_pcm, the settle counter increments. The (SETTLE+1)th en_pcm of the run is the first one captured; the state moves to RUN on that pulse. If SETTLE=0, go directly to RUN.
  - RUN: every en_pcm triggers a capture.
  - STOP: entered from SETTLE or RUN when enable=0 is sampled. Clocking continues until the end of the current frame (ph=2*HALF_DIV-1 and div=DECIM-1, where en_pcm fires). That final frame is captured if coming from RUN. Then go to IDLE with clk_pdm=0.
  - enable re-asserted while in STOP: ignored. Re-entry goes through IDLE and a full SETTLE.
- Clock and strobe timing, per cycle while not IDLE:
  - clk_pdm <= 0 at ph=0; clk_pdm <= 1 at ph=HALF_DIV.
  - At ph=HALF_DIV-3: din_l <= pdm_din; en_sample_l pulses the next cycle.
  - At ph=2*HALF_DIV-2: din_r <= pdm_din; en_sample_r pulses the next cycle.
  - At ph=2*HALF_DIV-1: ph wraps and div increments. If div=DECIM-1, div wraps and en_pcm pulses the next cycle.
  - din_l and din_r hold their values between strobes.
- Capture:
  - The cycle after an en_pcm pulse, cic_l and cic_r are sampled into pcm_l and pcm_r.
  - pcm_valid is visible 2 cycles after the en_pcm pulse.
- Handshake:
  - pcm_valid stays high and pcm_l/pcm_r stay stable until valid&&ready.
  - On acceptance without a simultaneous capture, pcm_valid drops the next cycle.
  - Capture coinciding with acceptance: new data loaded, pcm_valid stays 1, no overrun.
  - Capture while valid&&!ready: the new frame is dropped, the old frame is retained, and overrun <= 1.
- overrun:
  - Sticky until clr_overrun=1.
  - If clr_overrun coincides with a new drop, overrun stays 1 (set wins).
- Arithmetic: counters are unsigned, sized by $clog2. No arithmetic on sample data.

Decomposition:
- Shared package pdm_pkg: FSM state enum (IDLE, SETTLE, RUN, STOP) and the ph strobe offsets (L_OFS=3, R_OFS=2) as localparams.
- One natural sub-module, pdm_timebase: ph/div counters, clk_pdm, and the three raw strobes, gated by a run input.
- The FSM, capture register, and handshake stay in pdm_mic_ctrl.

Test Plan:
- Reset hold, then release with enable=0 for 100 cycles -> every output stays 0.
- enable=1 at cycle 0 (defaults, 20 clk/PDM period) -> clk_pdm period is 20 with a 10/10 duty cycle; en_sample_l fires at ph=8 and en_sample_r at ph=19; en_pcm pulses every 1280 cycles, first at cycle 1280.
- Defaults with cic_l=16'h1234 and cic_r=16'hFEDC driven constant, pcm_ready=1 -> the first four en_pcm pulses are not captured; first pcm_valid at cycle 6402 carrying 1234/FEDC; pcm_valid drops the next cycle.
- pcm_ready=0 across two captures -> pcm_l/pcm_r hold the first frame and overrun=1. clr_overrun pulse -> overrun=0. clr_overrun in the same cycle as a drop -> overrun stays 1.
- Accept (valid&&ready) in the same cycle as a capture -> pcm_valid stays 1 with the new data and overrun stays 0.
- enable=0 mid-frame in RUN -> clocking continues until that frame's en_pcm, one final frame is delivered, then IDLE with clk_pdm=0. A rst_n pulse mid-frame instead -> all outputs 0 on the next cycle and no frame is delivered.
